// File: rtl/accum_pkg.sv
// accum_pkg: shared types and defaults for the round-robin accumulator scheduler.
//   state_t    : scheduler FSM states (IDLE / RUN / SNAP)
//   DEF_*      : default increment width, accumulator width and window length
//   ptr_w()    : width of a requester index / round-robin pointer
package accum_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        SNAP = 2'd2
    } state_t;

    localparam int DEF_DW     = 8;
    localparam int DEF_AW     = 16;
    localparam int DEF_WINDOW = 256;

    // At least one bit so a 1-requester build still has a legal vector.
    function automatic int ptr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: rotate-priority one-hot select starting at ptr, plus the ptr register.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : synchronous pointer reset to 0
//   en         : grant enable (grant forced to 0 when low)
//   req_valid  : pending requests, one bit per requester
//   grant      : one-hot grant, at most one bit set
//   idx        : encoded index of the selected requester
module rr_arbiter
    import accum_pkg::*;
#(
    parameter  int N_REQ = 4,
    localparam int PW    = ptr_w(N_REQ)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             en,
    input  logic [N_REQ-1:0] req_valid,
    output logic [N_REQ-1:0] grant,
    output logic [PW-1:0]    idx
);

    logic [PW-1:0] ptr;
    logic [PW:0]   cand;
    logic          found;

    // Walk ptr, ptr+1, ... modulo N_REQ; the first valid requester wins.
    // cand is one bit wider so ptr+k never wraps before the modulo fold.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = {1'b0, ptr} + (PW+1)'(k);
            if (cand >= (PW+1)'(N_REQ))
                cand = cand - (PW+1)'(N_REQ);
            if (!found && req_valid[cand[PW-1:0]]) begin
                found = 1'b1;
                idx   = cand[PW-1:0];
            end
        end
        grant = (en && found) ? ({{(N_REQ-1){1'b0}}, 1'b1} << idx) : '0;
    end

    // Advance past the winner only on an actual handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ptr <= '0;
        else if (clear)
            ptr <= '0;
        else if (|grant)
            ptr <= (idx == PW'(N_REQ - 1)) ? '0 : idx + PW'(1);
    end

endmodule

// File: rtl/accum_rr_sched.sv
// accum_rr_sched: round-robin shared accumulator with fixed-length measurement windows.
//   clk, rst_n : clock, asynchronous active-low reset
//   enable     : 1 runs windows, 0 pauses (acc and window count held)
//   clear      : synchronous clear of acc, window, overflow, pointer, grant_id
//   req_valid  : per-requester pending flag
//   req_data   : per-requester unsigned increment, requester i in [i*DW +: DW]
//   req_ready  : one-hot grant
//   grant_id   : index of the last accepted requester
//   acc_out    : live accumulator
//   snap_out   : accumulator captured at the last window end
//   snap_valid : one-cycle pulse when snap_out updates
//   overflow   : sticky accumulator carry-out flag
module accum_rr_sched
    import accum_pkg::*;
#(
    parameter  int N_REQ  = 4,
    parameter  int DW     = DEF_DW,
    parameter  int AW     = DEF_AW,
    parameter  int WINDOW = DEF_WINDOW,
    localparam int PW     = ptr_w(N_REQ),
    localparam int CW     = $clog2(WINDOW)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic                clear,
    input  logic [N_REQ-1:0]    req_valid,
    input  logic [N_REQ*DW-1:0] req_data,
    output logic [N_REQ-1:0]    req_ready,
    output logic [PW-1:0]       grant_id,
    output logic [AW-1:0]       acc_out,
    output logic [AW-1:0]       snap_out,
    output logic                snap_valid,
    output logic                overflow
);

    state_t        state, state_nx;
    logic [CW-1:0] wcnt;
    logic [AW-1:0] acc;
    logic [PW-1:0] idx;
    logic [DW-1:0] data;
    logic [AW:0]   sum;
    logic          run, last, hs;

    assign run     = (state == RUN) && !clear;
    assign last    = (wcnt == CW'(WINDOW - 1));
    assign hs      = |req_ready;
    assign data    = req_data[int'(idx)*DW +: DW];
    assign sum     = {1'b0, acc} + {{(AW+1-DW){1'b0}}, data};
    assign acc_out = acc;

    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .en        (run),
        .req_valid (req_valid),
        .grant     (req_ready),
        .idx       (idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // A completed window always closes through SNAP, even if enable drops
    // on its last RUN cycle, so the counter never runs past WINDOW-1.
    always_comb begin
        state_nx = state;
        state_nx = clear                      ? IDLE :
                   (state == RUN && last)     ? SNAP :
                   enable                     ? RUN  : IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wcnt       <= '0;
            acc        <= '0;
            snap_out   <= '0;
            snap_valid <= 1'b0;
            overflow   <= 1'b0;
            grant_id   <= '0;
        end else begin
            snap_valid <= 1'b0;
            if (clear) begin
                wcnt     <= '0;
                acc      <= '0;
                overflow <= 1'b0;
                grant_id <= '0;
            end else if (state == SNAP) begin
                snap_out   <= acc;
                acc        <= '0;
                wcnt       <= '0;
                snap_valid <= 1'b1;
            end else if (state == RUN) begin
                // Count saturates at WINDOW-1 and is cleared at the SNAP edge.
                if (!last)
                    wcnt <= wcnt + CW'(1);
                if (hs) begin
                    acc      <= sum[AW-1:0];
                    grant_id <= idx;
                    overflow <= overflow | sum[AW];
                end
            end
        end
    end

endmodule

// File: tb/tb_accum_rr_sched.sv
// tb_accum_rr_sched: directed self-checking bench for accum_rr_sched.
module tb_accum_rr_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable, clear;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic [1:0]  grant_id;
    logic [15:0] acc_out, snap_out;
    logic        snap_valid, overflow;

    logic        en_b, clr_b;
    logic [3:0]  rv_b;
    logic [31:0] rd_b;
    logic [3:0]  rdy_b;
    logic [1:0]  gid_b;
    logic [15:0] acc_b, snap_b;
    logic        sv_b, ov_b;

    int checks = 0;
    int failures = 0;
    int n;

    always #5 clk = ~clk;

    accum_rr_sched #(.N_REQ(4), .DW(8), .AW(16), .WINDOW(8)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .clear(clear),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .grant_id(grant_id), .acc_out(acc_out), .snap_out(snap_out),
        .snap_valid(snap_valid), .overflow(overflow)
    );

    accum_rr_sched #(.N_REQ(4), .DW(8), .AW(16), .WINDOW(512)) dut_b (
        .clk(clk), .rst_n(rst_n), .enable(en_b), .clear(clr_b),
        .req_valid(rv_b), .req_data(rd_b), .req_ready(rdy_b),
        .grant_id(gid_b), .acc_out(acc_b), .snap_out(snap_b),
        .snap_valid(sv_b), .overflow(ov_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_clear();
        enable = 1'b0;
        clear  = 1'b1;
        tick();
        clear  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; enable = 1'b0; clear = 1'b0; req_valid = '0; req_data = '0;
        en_b = 1'b0; clr_b = 1'b0; rv_b = '0; rd_b = '0;
        repeat (2) @(negedge clk);
        check("rst_acc",   32'(acc_out), 32'h0);
        check("rst_snap",  32'(snap_out), 32'h0);
        check("rst_sv",    32'(snap_valid), 32'h0);
        check("rst_ov",    32'(overflow), 32'h0);
        check("rst_gid",   32'(grant_id), 32'h0);
        check("rst_rdy",   32'(req_ready), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Empty windows: snap_valid every 9 cycles, snapshot 0.
        enable = 1'b1;
        tick();
        for (int p = 0; p < 2; p++) begin
            n = 0;
            repeat (8) begin
                tick();
                n += int'(snap_valid);
            end
            check("idle_win_nopulse", 32'(n), 32'h0);
            tick();
            check("idle_win_pulse", 32'(snap_valid), 32'h1);
            check("idle_win_snap",  32'(snap_out), 32'h0);
            check("idle_win_acc",   32'(acc_out), 32'h0);
        end
        do_clear();

        // Round-robin over all four requesters, data 1,2,3,4.
        req_valid = 4'hF;
        req_data  = 32'h04030201;
        enable    = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) begin
            check("rr_ready", 32'(req_ready), 32'(1 << (i % 4)));
            tick();
            check("rr_gid", 32'(grant_id), 32'(i % 4));
            if (i == 3) check("rr_acc_mid", 32'(acc_out), 32'd10);
        end
        check("rr_acc_end",  32'(acc_out), 32'd20);
        check("rr_snap_rdy", 32'(req_ready), 32'h0);
        tick();
        check("rr_sv",   32'(snap_valid), 32'h1);
        check("rr_snap", 32'(snap_out), 32'd20);
        check("rr_acc0", 32'(acc_out), 32'h0);
        do_clear();
        check("clr_gid",  32'(grant_id), 32'h0);
        check("clr_acc",  32'(acc_out), 32'h0);
        check("clr_snap", 32'(snap_out), 32'd20);

        // Pointer skips idle requesters 0 and 2.
        req_valid = 4'b1010;
        req_data  = 32'h01010101;
        enable    = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            check("skip_ready", 32'(req_ready), (i % 2 == 1) ? 32'h8 : 32'h2);
            tick();
            check("skip_gid", 32'(grant_id), (i % 2 == 1) ? 32'd3 : 32'd1);
        end
        check("skip_acc", 32'(acc_out), 32'd4);
        do_clear();

        // Pause at wcnt=3 for 5 cycles delays the snapshot by 5 cycles.
        req_valid = 4'b0001;
        req_data  = 32'h00000001;
        enable    = 1'b1;
        tick();
        repeat (3) tick();
        check("pause_acc3", 32'(acc_out), 32'd3);
        enable = 1'b0;
        check("pause_last_run_rdy", 32'(req_ready), 32'h1);
        tick();
        for (int i = 0; i < 4; i++) begin
            check("pause_rdy", 32'(req_ready), 32'h0);
            check("pause_acc", 32'(acc_out), 32'd4);
            tick();
        end
        enable = 1'b1;
        tick();
        check("resume_acc", 32'(acc_out), 32'd4);
        check("resume_rdy", 32'(req_ready), 32'h1);
        n = 0;
        repeat (4) begin
            tick();
            n += int'(snap_valid);
        end
        check("pause_nopulse", 32'(n), 32'h0);
        check("pause_acc8",    32'(acc_out), 32'd8);
        tick();
        check("pause_sv",   32'(snap_valid), 32'h1);
        check("pause_snap", 32'(snap_out), 32'd8);

        // Clear during SNAP aborts the snapshot.
        req_data = 32'h00000002;
        repeat (8) tick();
        check("snapclr_acc16", 32'(acc_out), 32'd16);
        check("snapclr_rdy",   32'(req_ready), 32'h0);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("snapclr_sv",   32'(snap_valid), 32'h0);
        check("snapclr_snap", 32'(snap_out), 32'd8);
        check("snapclr_acc",  32'(acc_out), 32'h0);
        check("snapclr_idle", 32'(req_ready), 32'h0);
        tick();
        check("snapclr_run", 32'(req_ready), 32'h1);
        do_clear();

        // Overflow: 256 x 0xFF + 0xF0 = 0xFFF0, then + 0x20 wraps to 0x0010.
        en_b = 1'b1;
        rv_b = 4'b0001;
        rd_b = 32'h000000FF;
        tick();
        repeat (256) tick();
        check("ov_acc_ff00", 32'(acc_b), 32'hFF00);
        rd_b = 32'h000000F0;
        tick();
        check("ov_acc_fff0", 32'(acc_b), 32'hFFF0);
        check("ov_pre",      32'(ov_b), 32'h0);
        rd_b = 32'h00000020;
        tick();
        check("ov_acc_wrap", 32'(acc_b), 32'h0010);
        check("ov_set",      32'(ov_b), 32'h1);
        rv_b = '0;
        repeat (3) tick();
        check("ov_sticky",   32'(ov_b), 32'h1);
        check("ov_acc_hold", 32'(acc_b), 32'h0010);
        clr_b = 1'b1;
        tick();
        clr_b = 1'b0;
        check("ov_clr",     32'(ov_b), 32'h0);
        check("ov_clr_acc", 32'(acc_b), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
